// File: rtl/jh_pkg.sv
// Shared constants and byte-lane helpers for the JH finalisation pipeline.
package jh_pkg;

  localparam int         F8_LAT_DEF = 45;
  localparam logic [7:0] PAD_BYTE   = 8'h80;

  function automatic logic [127:0] bswap128(input logic [127:0] x);
    logic [127:0] y;
    y = 128'h0;
    for (int i = 0; i < 16; i++) begin
      y[8*i +: 8] = x[8*(15-i) +: 8];
    end
    return y;
  endfunction

  function automatic logic [511:0] bswap512(input logic [511:0] x);
    logic [511:0] y;
    y = 512'h0;
    for (int i = 0; i < 64; i++) begin
      y[8*i +: 8] = x[8*(63-i) +: 8];
    end
    return y;
  endfunction

  // Message length as a big-endian 128-bit integer, placed in the data byte lanes.
  function automatic logic [127:0] len_xor(input int unsigned msg_bits);
    return bswap128({96'h0, msg_bits});
  endfunction

endpackage

// File: rtl/jh_delay_line.sv
// Fixed-depth shift register; CLR enables a synchronous clear of every stage on rst_n low.
module jh_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1,
  parameter bit CLR   = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [DEPTH];

  // Shift chain, optionally cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (CLR && !rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/jh_f8.sv
// F8 round block with the core's interface and latency: a linear mixing stage
// (rotations plus round key) followed by a latency-matching register chain.
module jh_f8 #(
  parameter int LAT = 45
) (
  input  logic          clk,
  input  logic [1023:0] d,
  output logic [1023:0] q
);

  localparam logic [1023:0] KEY = {16{64'h0123_4567_89ab_cdef}};

  logic [1023:0] mix_s;
  logic [1023:0] pipe_r [LAT];

  assign mix_s = {d[506:0], d[1023:507]} ^ {d[1022:0], d[1023]} ^ KEY;

  // Unreset datapath pipeline
  always_ff @(posedge clk) begin
    pipe_r[0] <= mix_s;
    for (int i = 1; i < LAT; i++) begin
      pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign q = pipe_r[LAT-1];

endmodule

// File: rtl/jh_final_pipe.sv
// JH finalisation pipeline: data/pad block and length block through two F8 instances,
// producing a byte-reversed, truncated digest qualified by a tag-carrying valid chain.
module jh_final_pipe
  import jh_pkg::*;
#(
  parameter int  HASH_BITS = 512,
  parameter int  MSG_BITS  = 640,
  parameter int  F8_LAT    = F8_LAT_DEF,
  parameter int  TAG_W     = 32,
  localparam int LAT       = 2 * F8_LAT + 4,
  localparam int CNT_W     = $clog2(LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1023:0]        in_state,
  input  logic [127:0]         in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  output logic [HASH_BITS-1:0] out_hash,
  output logic [TAG_W-1:0]     out_tag,
  output logic [CNT_W-1:0]     in_flight
);

  localparam logic [127:0] LEN_C = len_xor(MSG_BITS);

  if (HASH_BITS != 224 && HASH_BITS != 256 && HASH_BITS != 384 && HASH_BITS != 512) begin : g_bad_hash_bits
    $error("jh_final_pipe: HASH_BITS must be 224, 256, 384 or 512");
  end

  logic [1023:0]          state_r;
  logic [127:0]           data_r;
  logic [1023:0]          s2_s;
  logic [1023:0]          f8a_q_s;
  logic [1023:0]          s3_r;
  logic [127:0]           data_dly_s;
  logic [1023:0]          s4_s;
  logic [1023:0]          f8b_q_s;
  logic [511:0]           s5_r;
  logic [511:0]           s6_s;
  logic [HASH_BITS-1:0]   hash_r;
  logic [TAG_W:0]         vt_q_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   unused_bits_s;

  // S1: capture midstate and the byte-reversed data word
  always_ff @(posedge clk) begin
    state_r <= in_state;
    data_r  <= bswap128(in_data);
  end

  assign s2_s = state_r ^ {888'h0, PAD_BYTE, data_r};

  jh_f8 #(.LAT(F8_LAT)) u_f8_data (.clk(clk), .d(s2_s), .q(f8a_q_s));

  // S3 register on the first F8 output
  always_ff @(posedge clk) begin
    s3_r <= f8a_q_s;
  end

  // The data word must arrive at S4 alongside the state it was absorbed into
  jh_delay_line #(.W(128), .DEPTH(F8_LAT + 1), .CLR(1'b0)) u_data_dly (
    .clk(clk), .rst_n(rst_n), .d(data_r), .q(data_dly_s)
  );

  assign s4_s = s3_r ^ {376'h0, PAD_BYTE, data_dly_s, LEN_C, 384'h0};

  jh_f8 #(.LAT(F8_LAT)) u_f8_len (.clk(clk), .d(s4_s), .q(f8b_q_s));

  // S5 keeps only the upper half; the lower half never reaches the digest
  always_ff @(posedge clk) begin
    s5_r <= f8b_q_s[1023:512];
  end

  assign s6_s          = bswap512(s5_r ^ {LEN_C, 384'h0});
  assign unused_bits_s = ^{f8b_q_s[511:0], s6_s};

  // S6 output register, truncated to the low digest bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash_r <= '0;
    end else begin
      hash_r <= s6_s[HASH_BITS-1:0];
    end
  end

  jh_delay_line #(.W(TAG_W + 1), .DEPTH(LAT), .CLR(1'b1)) u_vt_chain (
    .clk(clk), .rst_n(rst_n), .d({in_valid, in_tag}), .q(vt_q_s)
  );

  // Occupancy next-state: accept and retire in the same cycle cancel out
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({in_valid, out_valid})
      2'b10: begin
        if (cnt_r != CNT_W'(LAT)) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != CNT_W'(0)) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Occupancy register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign out_valid = vt_q_s[TAG_W];
  assign out_tag   = vt_q_s[TAG_W-1:0];
  assign out_hash  = hash_r;
  assign in_flight = cnt_r;

endmodule

// File: tb/tb_jh_final_pipe.sv
// Self-checking bench for jh_final_pipe: byte-level reference model, in-order scoreboard,
// and a second HASH_BITS=256 instance driven in parallel.
module tb_jh_final_pipe;

  localparam int LAT = 94;
  localparam int MSG = 640;
  localparam logic [1023:0] F8_KEY    = {16{64'h0123_4567_89ab_cdef}};
  localparam logic [1023:0] VEC_STATE = {16{64'h6a09_e667_bb67_ae85}} ^ {8{128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0}};
  localparam logic [127:0]  VEC_DATA  = 128'h4041_4243_4445_4647_4849_4a4b_4c4d_4e4f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid;
  logic [1023:0] in_state;
  logic [127:0]  in_data;
  logic [31:0]   in_tag;
  logic          out_valid, out_valid2;
  logic [511:0]  out_hash;
  logic [255:0]  out_hash2;
  logic [31:0]   out_tag, out_tag2;
  logic [6:0]    in_flight, in_flight2;

  jh_final_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid), .out_hash(out_hash), .out_tag(out_tag), .in_flight(in_flight)
  );

  jh_final_pipe #(.HASH_BITS(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_state(in_state), .in_data(in_data),
    .in_tag(in_tag), .out_valid(out_valid2), .out_hash(out_hash2), .out_tag(out_tag2), .in_flight(in_flight2)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1023:0] m_f8(input logic [1023:0] x);
    logic [1023:0] k;
    logic [1023:0] y;
    k = F8_KEY;
    for (int i = 0; i < 1024; i++) y[i] = x[(i + 1024 - 517) % 1024] ^ x[(i + 1023) % 1024] ^ k[i];
    return y;
  endfunction

  // Big-endian byte j of the 128-bit length goes to lane j, like message byte j
  function automatic logic [127:0] m_len_lanes(input int msg);
    logic [127:0] v;
    v = 128'h0;
    for (int j = 12; j < 16; j++) v[8*j +: 8] = 8'((msg >> (8 * (15 - j))) & 255);
    return v;
  endfunction

  function automatic logic [511:0] m_hash(input logic [1023:0] st, input logic [127:0] dat);
    logic [1023:0] b;
    logic [127:0]  ln;
    logic [511:0]  hi;
    logic [511:0]  r;
    ln = m_len_lanes(MSG);
    b = st;
    for (int j = 0; j < 16; j++) b[8*j +: 8] ^= dat[127 - 8*j -: 8];
    b[135:128] ^= 8'h80;
    b = m_f8(b);
    for (int j = 0; j < 16; j++) b[512 + 8*j +: 8] ^= dat[127 - 8*j -: 8];
    b[647:640] ^= 8'h80;
    b[511:384] ^= ln;
    b = m_f8(b);
    hi = b[1023:512];
    hi[511:384] ^= ln;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = hi[8*(63 - k) +: 8];
    return r;
  endfunction

  function automatic logic [1023:0] rnd1024();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  typedef struct {
    logic [31:0]  tag;
    logic [511:0] hash;
    int           due;
  } item_t;

  item_t sb[$];
  int    ncyc = 0;
  int    peak = 0;

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      ncyc++;
      check("in_flight", in_flight, sb.size());
      check("in_flight_256", in_flight2, sb.size());
      if (int'(in_flight) > peak) peak = int'(in_flight);
      if (sb.size() > 0 && sb[0].due == ncyc) begin
        it = sb.pop_front();
        check("out_valid", out_valid, 1);
        check("out_tag", out_tag, it.tag);
        check("out_hash", out_hash, it.hash);
        check("out_valid_256", out_valid2, 1);
        check("out_tag_256", out_tag2, it.tag);
        check("out_hash_256", out_hash2, it.hash[255:0]);
      end else begin
        check("out_valid_idle", out_valid, 0);
        check("out_valid_idle_256", out_valid2, 0);
      end
      if (!rst_n) begin
        sb.delete();
      end else if (in_valid) begin
        it.tag  = in_tag;
        it.hash = m_hash(in_state, in_data);
        it.due  = ncyc + LAT;
        sb.push_back(it);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb.size() != 0 || in_flight != 7'd0) && k < LAT + 20) begin
      step();
      k++;
    end
    check(name, in_flight, 0);
    check({name, "_sb"}, sb.size(), 0);
  endtask

  initial begin
    int unsigned   msg_v;
    logic [1023:0] t;
    logic [511:0]  h;
    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_data = '0; in_tag = '0;

    // Model pins
    msg_v = 640;
    check("model_len", m_len_lanes(MSG), {16'h8002, 112'h0});
    check("pkg_len_xor", jh_pkg::len_xor(msg_v), {16'h8002, 112'h0});
    t = m_f8(1024'h1) ^ F8_KEY;
    check("model_f8_lo", t[511:0], 512'h2);
    check("model_f8_hi", t[1023:512], 512'h20);

    repeat (200) begin
      step();
      check("rst_hash", out_hash, 0);
      check("rst_hash_256", out_hash2, 0);
      check("rst_tag", out_tag, 0);
      check("rst_flight", in_flight, 0);
    end
    rst_n = 1'b1;
    repeat (5) step();

    // Single vector with exact latency
    in_valid = 1'b1; in_tag = 32'h1234; in_state = VEC_STATE; in_data = VEC_DATA;
    step();
    in_valid = 1'b0;
    repeat (LAT - 2) step();
    check("vec_not_early", out_valid, 0);
    step();
    h = m_hash(VEC_STATE, VEC_DATA);
    check("vec_valid_at_lat", out_valid, 1);
    check("vec_tag", out_tag, 32'h1234);
    check("vec_hash", out_hash, h);
    check("vec_hash_256", out_hash2, h[255:0]);
    drain("vec_drain");

    // Back-to-back stream
    peak = 0;
    for (int i = 0; i < 500; i++) begin
      in_valid = 1'b1; in_tag = i;
      in_state = {32{32'(i) * 32'h9e37_79b9}};
      in_data  = {4{~32'(i)}};
      step();
    end
    in_valid = 1'b0;
    drain("stream_drain");
    check("stream_peak", peak, LAT);

    // Gapped random stream
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_tag = 1000 + i;
      in_state = rnd1024();
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    drain("gapped_drain");

    // Reset pulse with 40 items in flight; the item offered during reset is dropped too
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_tag = 2000 + i; in_state = rnd1024(); in_data = {4{$urandom}};
      step();
    end
    rst_n = 1'b0; in_tag = 32'd2999;
    step();
    rst_n = 1'b1; in_tag = 32'd3000; in_state = VEC_STATE; in_data = VEC_DATA;
    step();
    in_valid = 1'b0;
    check("post_rst_flight", in_flight, 1);
    repeat (LAT - 1) step();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_tag", out_tag, 32'd3000);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
